// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: decodes byte/half/word loads and stores, issues one aligned bus request per access.
// Stalls the pipeline from accept through the ack (or timeout) cycle; result or bus error is presented in the DONE cycle.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid,
    input  logic [31:0]           instruction,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  exc_misaligned,
    output logic                  exc_bus,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_q, req_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    store_q, store_d;
    logic                    uns_q, uns_d;
    size_t                   size_q, size_d;
    logic [1:0]              off_q, off_d;
    logic [31:0]             load_data_q, load_data_d;
    logic                    load_valid_q, load_valid_d;
    logic                    exc_bus_q, exc_bus_d;

    logic [5:0]  opcode;
    logic        dec_mem;
    logic        dec_store;
    logic        dec_uns;
    size_t       dec_size;
    logic        misaligned;
    logic        op_live;
    logic        accept;
    logic [3:0]  be_le;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    logic [1:0]  rd_lane;
    logic        rd_hsel;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    logic        unused_instr;

    assign opcode       = instruction[31:26];
    assign unused_instr = ^instruction[25:0];

    always_comb begin
        dec_mem   = 1'b1;
        dec_store = 1'b0;
        dec_uns   = 1'b0;
        dec_size  = SZ_W;
        case (opcode)
            OP_LB:   dec_size = SZ_B;
            OP_LH:   dec_size = SZ_H;
            OP_LW:   dec_size = SZ_W;
            OP_LBU: begin
                dec_size = SZ_B;
                dec_uns  = 1'b1;
            end
            OP_LHU: begin
                dec_size = SZ_H;
                dec_uns  = 1'b1;
            end
            OP_SB: begin
                dec_size  = SZ_B;
                dec_store = 1'b1;
            end
            OP_SH: begin
                dec_size  = SZ_H;
                dec_store = 1'b1;
            end
            OP_SW:   dec_store = 1'b1;
            default: dec_mem = 1'b0;
        endcase
    end

    assign misaligned = ((dec_size == SZ_H) && addr[0]) ||
                        ((dec_size == SZ_W) && (addr[1:0] != 2'b00));

    // Only an IDLE, out-of-reset cycle looks at the pipeline's valid.
    assign op_live        = !reset && valid && dec_mem && (state_q == S_IDLE);
    assign exc_misaligned = op_live && misaligned;
    assign accept         = op_live && !misaligned;

    always_comb begin
        be_le     = 4'b1111;
        wdata_new = store_data;
        case (dec_size)
            SZ_B: begin
                be_le     = 4'b0001 << addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            SZ_H: begin
                be_le     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{store_data[15:0]}};
            end
            default: begin
                be_le     = 4'b1111;
                wdata_new = store_data;
            end
        endcase
    end

    assign be_new = BIG_ENDIAN ? {be_le[0], be_le[1], be_le[2], be_le[3]} : be_le;

    // Big-endian places byte offset k on lane 3-k, i.e. the inverted offset.
    assign rd_lane = BIG_ENDIAN ? ~off_q : off_q;
    assign rd_hsel = BIG_ENDIAN ? ~off_q[1] : off_q[1];
    assign rd_byte = mem_rdata[{rd_lane, 3'b000} +: 8];
    assign rd_half = mem_rdata[{rd_hsel, 4'b0000} +: 16];

    always_comb begin
        rd_ext = mem_rdata;
        case (size_q)
            SZ_B:    rd_ext = uns_q ? {24'h000000, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_H:    rd_ext = uns_q ? {16'h0000, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        store_d      = store_q;
        uns_d        = uns_q;
        size_d       = size_q;
        off_d        = off_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        exc_bus_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = dec_store;
                    addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
                    be_d    = be_new;
                    wdata_d = wdata_new;
                    store_d = dec_store;
                    uns_d   = dec_uns;
                    size_d  = dec_size;
                    off_d   = addr[1:0];
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // An ack on the last allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!store_q) begin
                        load_valid_d = 1'b1;
                        load_data_d  = rd_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    exc_bus_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= 4'b0000;
            wdata_q      <= 32'h0;
            store_q      <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= SZ_B;
            off_q        <= 2'b00;
            load_data_q  <= 32'h0;
            load_valid_q <= 1'b0;
            exc_bus_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            store_q      <= store_d;
            uns_q        <= uns_d;
            size_q       <= size_d;
            off_q        <= off_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            exc_bus_q    <= exc_bus_d;
        end
    end

    assign stall      = accept || (!reset && (state_q == S_WAIT));
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_be     = be_q;
    assign mem_wdata  = wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign exc_bus    = exc_bus_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: little- and big-endian instances share stimulus and bus responses.
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid;
    logic [31:0] instruction;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        ack_auto, ack_dir;
    logic [31:0] rd_auto, rd_dir;
    bit          auto_en;
    bit          mon_en;
    bit          abort_run;

    logic        stall_w [2];
    logic [31:0] load_data_w [2];
    logic        load_valid_w [2];
    logic        exc_mis_w [2];
    logic        exc_bus_w [2];
    logic        mem_req_w [2];
    logic        mem_we_w [2];
    logic [31:0] mem_addr_w [2];
    logic [3:0]  mem_be_w [2];
    logic [31:0] mem_wdata_w [2];

    assign mem_ack   = auto_en ? ack_auto : ack_dir;
    assign mem_rdata = auto_en ? rd_auto : rd_dir;

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT(TO), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .valid(valid), .instruction(instruction),
        .addr(addr), .store_data(store_data), .stall(stall_w[0]),
        .load_data(load_data_w[0]), .load_valid(load_valid_w[0]),
        .exc_misaligned(exc_mis_w[0]), .exc_bus(exc_bus_w[0]),
        .mem_req(mem_req_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_be(mem_be_w[0]), .mem_wdata(mem_wdata_w[0]),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT(TO), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .reset(reset), .valid(valid), .instruction(instruction),
        .addr(addr), .store_data(store_data), .stall(stall_w[1]),
        .load_data(load_data_w[1]), .load_valid(load_valid_w[1]),
        .exc_misaligned(exc_mis_w[1]), .exc_bus(exc_bus_w[1]),
        .mem_req(mem_req_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_be(mem_be_w[1]), .mem_wdata(mem_wdata_w[1]),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] wdata;
    } req_exp_t;

    typedef struct {
        int          kind;      // 0 load, 1 store, 2 bus error
        logic [31:0] d0;
        logic [31:0] d1;
        int          stall_len;
        int          req_len;
    } cmp_exp_t;

    typedef struct {
        int          dly;       // WAIT cycle carrying the ack, 0 = never
        logic [31:0] rdata;
    } ack_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          dly;
    } stim_t;

    req_exp_t q_req[$];
    cmp_exp_t q_cmp[$];
    ack_t     q_ack[$];

    int total = 0;
    int bad   = 0;

    logic [5:0] mem_ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    stim_t dir_tab [14] = '{
        '{6'h23, 32'h100, 32'h0,        32'hDEADBEEF, 1},
        '{6'h20, 32'h103, 32'h0,        32'h80AABBCC, 2},
        '{6'h24, 32'h103, 32'h0,        32'h80AABBCC, 1},
        '{6'h21, 32'h102, 32'h0,        32'h80AABBCC, 1},
        '{6'h25, 32'h102, 32'h0,        32'h80AABBCC, 1},
        '{6'h29, 32'h202, 32'h1234ABCD, 32'h0,        3},
        '{6'h23, 32'h101, 32'h0,        32'h0,        1},
        '{6'h21, 32'h103, 32'h0,        32'h0,        1},
        '{6'h28, 32'h103, 32'h55,       32'h0,        1},
        '{6'h23, 32'h104, 32'h0,        32'h11111111, 0},
        '{6'h23, 32'h108, 32'h0,        32'h22222222, TO},
        '{6'h00, 32'h100, 32'h0,        32'h0,        1},
        '{6'h28, 32'h100, 32'hA5,       32'h0,        2},
        '{6'h2B, 32'h10C, 32'hCAFEF00D, 32'h0,        5}
    };

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    endfunction

    function automatic bit op_uns(input logic [5:0] op);
        return (op == 6'h24) || (op == 6'h25);
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] a, input int sz, input bit bm);
        logic [3:0] be;
        int off, lane;
        be  = 4'b0000;
        off = int'(a[1:0]);
        for (int k = 0; k < sz; k++) begin
            lane = off + k;
            if (bm) be[3 - lane] = 1'b1;
            else    be[lane]     = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input int sz);
        if (sz == 1) return {4{sd[7:0]}};
        if (sz == 2) return {2{sd[15:0]}};
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                             input int sz, input bit uns, input bit bm);
        logic [7:0]  mb [4];
        logic [31:0] v;
        int off, lane;
        off = int'(a[1:0]);
        for (int k = 0; k < 4; k++) begin
            lane  = bm ? 3 - k : k;
            mb[k] = rd[8*lane +: 8];
        end
        v = 32'h0;
        for (int i = 0; i < sz; i++) begin
            if (bm) v = (v << 8) | 32'(mb[off + i]);
            else    v = v | (32'(mb[off + i]) << (8 * i));
        end
        if (sz < 4 && !uns && v[8*sz - 1]) v = v | (32'hFFFFFFFF << (8 * sz));
        return v;
    endfunction

    // ---------------- bus responder ----------------
    initial begin
        int   n;
        ack_t cur;
        n        = 0;
        cur      = '{0, 32'h0};
        ack_auto = 1'b0;
        rd_auto  = 32'h0;
        forever begin
            @(negedge clk);
            if (reset || !auto_en) begin
                n        = 0;
                ack_auto = 1'b0;
            end else if (mem_req_w[0]) begin
                n++;
                if (n == 1) begin
                    if (q_ack.size() > 0) cur = q_ack.pop_front();
                    else                  cur = '{0, 32'h0};
                end
                ack_auto = (cur.dly == n);
                rd_auto  = ack_auto ? cur.rdata : $urandom;
            end else begin
                // Acks outside a request must be ignored by the unit.
                n        = 0;
                ack_auto = 1'($urandom_range(0, 1));
                rd_auto  = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [31:0] last [2];
        req_exp_t    cr;
        cmp_exp_t    cc;
        bit          req_prev, have_cr;
        int          scnt, rcnt;
        last[0]  = 32'h0;
        last[1]  = 32'h0;
        req_prev = 1'b0;
        have_cr  = 1'b0;
        scnt     = 0;
        rcnt     = 0;
        cr       = '{32'h0, 1'b0, 4'h0, 4'h0, 32'h0};
        forever begin
            @(negedge clk);
            #2;
            if (!mon_en || reset) begin
                req_prev = 1'b0;
                scnt     = 0;
                rcnt     = 0;
                last[0]  = 32'h0;
                last[1]  = 32'h0;
                continue;
            end
            check("stall_lockstep", 96'(stall_w[1]), 96'(stall_w[0]));
            if (stall_w[0]) scnt++;
            if (mem_req_w[0] && !req_prev) begin
                if (q_req.size() > 0) begin
                    cr      = q_req.pop_front();
                    have_cr = 1'b1;
                end else begin
                    have_cr = 1'b0;
                    total++;
                    bad++;
                    $display("FAIL req_unexpected: got request addr %h expected none", mem_addr_w[0]);
                end
            end
            if (mem_req_w[0]) begin
                rcnt++;
                if (have_cr) begin
                    for (int d = 0; d < 2; d++)
                        check(d == 0 ? "req_fields_le" : "req_fields_be",
                              96'({mem_req_w[d], mem_we_w[d], mem_be_w[d], mem_addr_w[d], mem_wdata_w[d]}),
                              96'({1'b1, cr.we, (d == 0 ? cr.be0 : cr.be1), cr.addr, cr.wdata}));
                end
            end else if (req_prev) begin
                if (q_cmp.size() > 0) begin
                    cc = q_cmp.pop_front();
                    if (cc.kind == 0) begin
                        last[0] = cc.d0;
                        last[1] = cc.d1;
                    end
                    for (int d = 0; d < 2; d++)
                        check(d == 0 ? "done_le" : "done_be",
                              96'({mem_req_w[d], load_valid_w[d], exc_bus_w[d], load_data_w[d]}),
                              96'({1'b0, cc.kind == 0, cc.kind == 2, last[d]}));
                    check("stall_len", 96'(scnt), 96'(cc.stall_len));
                    check("req_len", 96'(rcnt), 96'(cc.req_len));
                end else begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got completion expected none");
                end
                scnt = 0;
                rcnt = 0;
            end else begin
                for (int d = 0; d < 2; d++)
                    check(d == 0 ? "idle_le" : "idle_be",
                          96'({mem_req_w[d], load_valid_w[d], exc_bus_w[d], load_data_w[d]}),
                          96'({3'b000, last[d]}));
            end
            req_prev = mem_req_w[0];
        end
    end

    // ---------------- driver ----------------
    task automatic drive_op(input bit v, input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] rd, input int dly);
        int  sz;
        bit  acc, mis, done, st;
        @(negedge clk);
        valid       = v;
        instruction = {op, 26'($urandom)};
        addr        = a;
        store_data  = sd;
        sz  = op_size(op);
        st  = op_store(op);
        acc = v && (sz != 0) && (int'(a[1:0]) % sz == 0);
        mis = v && (sz != 0) && !acc;
        if (acc) begin
            q_req.push_back('{{a[31:2], 2'b00}, st, exp_be(a, sz, 1'b0), exp_be(a, sz, 1'b1),
                              exp_wdata(sd, sz)});
            q_cmp.push_back('{(dly == 0) ? 2 : (st ? 1 : 0),
                              exp_load(rd, a, sz, op_uns(op), 1'b0),
                              exp_load(rd, a, sz, op_uns(op), 1'b1),
                              1 + ((dly == 0) ? TO : dly),
                              (dly == 0) ? TO : dly});
            q_ack.push_back('{dly, rd});
        end
        #1;
        for (int d = 0; d < 2; d++)
            check("stall_misaligned", 96'({stall_w[d], exc_mis_w[d]}), 96'({acc, mis}));
        if (acc) begin
            done = 1'b0;
            for (int i = 0; i < TO + 4 && !done; i++) begin
                @(negedge clk);
                if (!stall_w[0]) done = 1'b1;
            end
            if (!done) begin
                total++;
                bad++;
                $display("FAIL access_timeout: got stall still high expected release within %0d cycles", TO + 4);
                abort_run = 1'b1;
            end else begin
                // DONE cycle: a live mem op here must be ignored.
                valid       = 1'b1;
                instruction = {mem_ops[$urandom_range(0, 7)], 26'($urandom)};
                addr        = $urandom;
                #1;
                for (int d = 0; d < 2; d++)
                    check("done_ignores_valid", 96'({stall_w[d], exc_mis_w[d]}), 96'(0));
            end
        end
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a;
        int          dly, r;
        reset       = 1'b1;
        valid       = 1'b1;
        instruction = {6'h23, 26'h0};
        addr        = 32'h100;
        store_data  = 32'h0;
        auto_en     = 1'b1;
        mon_en      = 1'b0;
        abort_run   = 1'b0;
        ack_dir     = 1'b0;
        rd_dir      = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_ctrl", 96'({stall_w[d], exc_mis_w[d], mem_req_w[d], mem_we_w[d],
                                     load_valid_w[d], exc_bus_w[d]}), 96'(0));
            check("reset_data", 96'({mem_addr_w[d], mem_be_w[d], mem_wdata_w[d]}), 96'(0));
            check("reset_load_data", 96'(load_data_w[d]), 96'(0));
        end
        @(negedge clk);
        reset  = 1'b0;
        valid  = 1'b0;
        mon_en = 1'b1;

        foreach (dir_tab[i])
            if (!abort_run)
                drive_op(1'b1, dir_tab[i].op, dir_tab[i].a, dir_tab[i].sd, dir_tab[i].rd, dir_tab[i].dly);

        for (int i = 0; i < 250 && !abort_run; i++) begin
            r = int'($urandom_range(0, 19));
            if (r < 17) begin
                op = mem_ops[$urandom_range(0, 7)];
            end else begin
                op = 6'($urandom_range(0, 63));
                while (op_size(op) != 0) op = 6'($urandom_range(0, 63));
            end
            a = $urandom;
            r = int'($urandom_range(0, 9));
            if (r == 0)     dly = 0;
            else if (r < 7) dly = int'($urandom_range(1, 3));
            else            dly = int'($urandom_range(1, TO));
            drive_op($urandom_range(0, 9) != 0, op, a, $urandom, $urandom, dly);
        end

        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        check("queues_drained", 96'({32'(q_req.size()), 32'(q_cmp.size()), 32'(q_ack.size())}), 96'(0));

        // Reset in the middle of a WAIT, then a late ack.
        mon_en  = 1'b0;
        auto_en = 1'b0;
        if (!abort_run) begin
            @(negedge clk);
            valid       = 1'b1;
            instruction = {6'h23, 26'h0};
            addr        = 32'h300;
            @(negedge clk);
            valid = 1'b0;
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                check("mid_wait_req", 96'({mem_req_w[d], mem_addr_w[d]}), 96'({1'b1, 32'h300}));
            reset = 1'b1;
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++)
                check("reset_drops_req", 96'({mem_req_w[d], stall_w[d]}), 96'(0));
            @(negedge clk);
            reset   = 1'b0;
            ack_dir = 1'b1;
            rd_dir  = 32'hFFFFFFFF;
            repeat (3) begin
                @(negedge clk);
                #1;
                for (int d = 0; d < 2; d++)
                    check("late_ack_ignored", 96'({mem_req_w[d], load_valid_w[d], exc_bus_w[d],
                                                   stall_w[d], load_data_w[d]}), 96'(0));
            end
            ack_dir = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store unit sitting in the MEM stage between the pipeline and a variable-latency data memory. Decodes LB/LBU/LH/LHU/LW/SB/SH/SW from the instruction word and generates word-aligned bus requests with byte enables and lane-replicated store data. It waits on a req/ack handshake, stalls the pipeline, and returns sign- or zero-extended load data. It also flags misaligned accesses and bus timeouts.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte-address width; data path fixed at 32 bits / 4 byte lanes
- TIMEOUT, 16, max WAIT cycles without ack before a bus error (≥2)
- BIG_ENDIAN, 0, lane mapping: 0 = byte offset k on lane k, 1 = offset k on lane 3-k

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- valid  in  1  instruction in MEM stage is live
- instruction  in  32  full instruction word; opcode = bits [31:26]
- addr  in  ADDR_WIDTH  effective byte address
- store_data  in  32  rt value for stores
- stall  out  1  hold pipeline
- load_data  out  32  extended load result, valid while load_valid=1
- load_valid  out  1  one-cycle pulse, load completed
- exc_misaligned  out  1  alignment fault (combinational, IDLE only)
- exc_bus  out  1  one-cycle pulse, timeout
- mem_req, mem_we  out  1  bus request / write strobe
- mem_addr  out  ADDR_WIDTH  word address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, sampled on ack
- mem_ack  in  1  transaction complete

## Operation

- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Others: not memory ops, ignored.
- Size: byte / half / word. Alignment: half requires addr[0]=0. Word requires addr[1:0]=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, valid & mem op & misaligned:
  - exc_misaligned=1 the same cycle.
  - stall=0, no bus activity, stay IDLE.
- IDLE, valid & mem op & aligned:
  - stall=1.
  - Latch op, size, signedness, offset, addr, be, wdata.
  - Go to WAIT.
- WAIT:
  - mem_req=1, with mem_addr/mem_we/mem_be/mem_wdata held stable from latched values.
  - stall=1.
  - Wait counter increments each cycle.
  - If mem_ack=1: capture mem_rdata, go to DONE.
  - Else, if the counter reaches TIMEOUT-1: go to DONE with a bus-error flag.
  - Ack on the timeout cycle: ack wins, no error.
- DONE:
  - stall=0; pipeline advances at the end of this cycle.
  - load_valid=1 for a successful load; exc_bus=1 on timeout.
  - Always returns to IDLE. The valid input is ignored in DONE.
- Byte enables (BIG_ENDIAN=0):
  - byte: be = 1<<offset
  - half: 0011 (offset 0) or 1100 (offset 2)
  - word: 1111
  - BIG_ENDIAN=1 mirrors the lanes: byte offset 0 → 1000; half offset 0 → 1100.
- Write data: byte {4{sd[7:0]}}, half {2{sd[15:0]}}, word sd.
- Load data: select the enabled lane(s). LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_ack outside WAIT is ignored.
- mem_we=0 for loads; load_valid never pulses for stores.

## Timing

- Reset: state=IDLE, counter=0, and every registered output 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data, load_valid, exc_bus). stall and exc_misaligned are 0 since valid is ignored during reset.
- Reset asserted mid-WAIT or mid-DONE: IDLE on the next edge, mem_req low from then on. A late ack is ignored.
- Stall duration = 1 (IDLE) + N (WAIT cycles up to and including the ack cycle). Ack on the first WAIT cycle gives stall=1 for 2 cycles, then DONE.
- Back-to-back: a new mem op is accepted in the IDLE cycle immediately after DONE. Minimum 3 cycles per access.
- load_data holds its value until the next load completes.
- No ack: mem_req high exactly TIMEOUT cycles, then exc_bus for 1 cycle.

## Test plan

- LW addr 0x100, ack on first WAIT cycle, rdata 0xDEADBEEF → mem_addr 0x100, be 1111, we 0, stall 2 cycles, load_valid pulse with 0xDEADBEEF.
- LB addr 0x103, rdata 0x80AABBCC → be 1000, load_data 0xFFFFFF80. Same with LBU → 0x00000080. LH 0x102 → 0xFFFF80AA.
- SH addr 0x202, store_data 0x1234ABCD, ack after 3 WAIT cycles → mem_addr 0x200, we 1, be 1100, wdata 0xABCDABCD, stall 4 cycles, no load_valid.
- LW addr 0x101 and LH addr 0x103 → exc_misaligned=1 same cycle, stall 0, mem_req stays 0. SB 0x103 → no fault.
- TIMEOUT=16, never ack → mem_req high 16 cycles, exc_bus pulse, load_valid 0. Ack on the 16th WAIT cycle → normal completion, no exc_bus.
- reset asserted during WAIT, then ack → mem_req 0 after the edge, no load_valid. BIG_ENDIAN=1, SB offset 0 → be 1000. Opcode 0x00 with valid=1 → no stall, no request.
